// File: rtl/fifo_burst_reader_if.sv
// Bus bundle between the burst reader, the sync_fifo read port and the
// consuming PE's input stream.
//
// Stream handshake: a word moves from producer to consumer on every rising
// clk edge where out_valid && out_ready are both high. The producer
// (master) holds out_data/out_last stable while out_valid is high and
// out_ready is low. out_valid never depends on out_ready.
//
// FIFO read port: fifo_rd_en is only raised while fifo_empty is low.
// fifo_data carries the word one cycle after the strobe.
interface fifo_burst_reader_if #(
  parameter int DATA_LEN = 8
);
  logic                fifo_rd_en;
  logic                fifo_empty;
  logic [DATA_LEN-1:0] fifo_data;
  logic                out_valid;
  logic [DATA_LEN-1:0] out_data;
  logic                out_last;
  logic                out_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data,
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data,
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains burst_len words from a sync_fifo with a one-cycle registered read
// and streams them out with out_last on the final word. A 2-entry skid
// buffer plus credit-based read issue keeps full rate and absorbs
// backpressure without losing words that are already in flight.
module fifo_burst_reader #(
  parameter int DATA_LEN = 8,
  parameter int LEN_W    = 4
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  fifo_burst_reader_if.master bus,
  output logic [1:0]       dbg_state,
  output logic [1:0]       dbg_occ,
  output logic [LEN_W-1:0] dbg_recv
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, issued_q, recv_q, sent_q;
  logic [LEN_W-1:0]    len_m1;
  logic [1:0]          occ_q;
  logic                wr_ptr_q, rd_ptr_q;
  logic                inflight_q;
  logic [DATA_LEN-1:0] mem_q [2];
  logic                done_q;
  logic                pop, push, accept, credit_ok;

  assign len_m1 = len_q - LEN_ONE;
  assign pop    = bus.out_valid && bus.out_ready;
  assign push   = inflight_q;
  assign accept = (state_q == IDLE) && start && (burst_len != '0);

  // A read may issue only if the word it returns still fits after counting
  // what is buffered and already in flight, less what leaves this cycle.
  assign credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_last  = bus.out_valid && (sent_q == len_m1);
  assign done          = done_q;
  assign dbg_state     = state_q;
  assign dbg_occ       = occ_q;
  assign dbg_recv      = recv_q;

  // State register.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state: RUN until the last read issues, DRAIN until the last word leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (bus.fifo_rd_en && (issued_q == len_m1)) state_d = DRAIN;
      DRAIN:   if (pop && bus.out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy and the credit-gated FIFO read strobe.
  always_comb begin
    busy           = (state_q != IDLE);
    bus.fifo_rd_en = (state_q == RUN) && !bus.fifo_empty &&
                     (issued_q < len_q) && credit_ok;
  end

  // Burst length latch and issued/received/sent counters.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      len_q    <= '0;
      issued_q <= '0;
      recv_q   <= '0;
      sent_q   <= '0;
    end else if (accept) begin
      len_q    <= burst_len;
      issued_q <= '0;
      recv_q   <= '0;
      sent_q   <= '0;
    end else begin
      if (bus.fifo_rd_en) issued_q <= issued_q + LEN_ONE;
      if (push)           recv_q   <= recv_q + LEN_ONE;
      if (pop)            sent_q   <= sent_q + LEN_ONE;
    end
  end

  // Read-latency tracker: high in the cycle the FIFO presents a requested word.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) inflight_q <= 1'b0;
    else            inflight_q <= bus.fifo_rd_en;
  end

  // Two-entry circular output buffer; pointers wrap modulo 2.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.fifo_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Completion pulse: cycle after a zero-length start or after the last handshake.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) done_q <= 1'b0;
    else            done_q <= ((state_q == IDLE) && start && (burst_len == '0)) ||
                              ((state_q == DRAIN) && pop && bus.out_last);
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural sync_fifo with registered read,
// word-order scoreboard, directed scenarios plus randomized bursts.
module tb_fifo_burst_reader;
  localparam int DATA_LEN = 8;
  localparam int LEN_W    = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic             busy, done;
  logic [1:0]       dbg_state, dbg_occ;
  logic [LEN_W-1:0] dbg_recv;

  always #5 clk = ~clk;

  fifo_burst_reader_if #(.DATA_LEN(DATA_LEN)) bus();

  fifo_burst_reader #(.DATA_LEN(DATA_LEN), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .bus       (bus.master),
    .dbg_state (dbg_state),
    .dbg_occ   (dbg_occ),
    .dbg_recv  (dbg_recv)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int e0       = 0;
  int hs_count, rd_cnt, done_cnt, done_cyc, first_hs, last_hs, act_cnt;
  int owed     = 0;
  int ready_mode = 0;
  int ready_phase = 0;

  logic [DATA_LEN-1:0] exp_q[$];
  logic [DATA_LEN-1:0] pending_q[$];
  logic [DATA_LEN-1:0] fifo_q[$];
  logic                fifo_wr = 1'b0;
  logic                fifo_flush = 1'b0;
  logic [DATA_LEN-1:0] fifo_wdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural sync_fifo: registered read data, registered empty flag.
  always @(posedge clk) begin
    if (fifo_flush) begin
      fifo_q.delete();
    end else begin
      if (bus.fifo_rd_en && fifo_q.size() > 0) bus.fifo_data <= fifo_q.pop_front();
      if (fifo_wr) fifo_q.push_back(fifo_wdata);
    end
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  // Consumer ready pattern: always, 1-0-0 repeating, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ((ready_phase % 3) == 0);
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    ready_phase++;
  end

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [DATA_LEN-1:0] w;
    if (sys_rst_n) begin
      check("occ_bound", 32'(dbg_occ <= 2'd2), 32'd1);
      if (bus.fifo_rd_en) begin
        rd_cnt++;
        check("rd_on_empty", 32'(bus.fifo_empty), 32'd0);
      end
      if (dbg_occ == 2'd2 && !bus.out_ready) check("rd_when_full", 32'(bus.fifo_rd_en), 32'd0);
      if (busy || bus.fifo_rd_en || bus.out_valid) act_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (hs_count == 0) first_hs = cyc;
        last_hs = cyc;
        hs_count++;
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(w));
          check("out_last", 32'(bus.out_last), 32'(exp_q.size() == 0 && owed == 0));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic fill(input logic [DATA_LEN-1:0] w);
    fifo_wr = 1'b1;
    fifo_wdata = w;
    if (owed > 0) begin
      exp_q.push_back(w);
      owed--;
    end else begin
      pending_q.push_back(w);
    end
    @(posedge clk); #1;
    fifo_wr = 1'b0;
  endtask

  task automatic flush_all();
    fifo_flush = 1'b1;
    pending_q.delete();
    exp_q.delete();
    owed = 0;
    @(posedge clk); #1;
    fifo_flush = 1'b0;
  endtask

  task automatic start_burst(input int len);
    for (int i = 0; i < len; i++) begin
      if (pending_q.size() > 0) exp_q.push_back(pending_q.pop_front());
      else owed++;
    end
    hs_count = 0; rd_cnt = 0; done_cnt = 0; act_cnt = 0;
    first_hs = 0; last_hs = 0; done_cyc = 0; ready_phase = 0;
    start = 1'b1;
    burst_len = LEN_W'(len);
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt > 0) break;
    end
    #1;
    check("done_seen", 32'(done_cnt > 0), 32'd1);
  endtask

  task automatic check_outputs_zero(input string phase);
    check({phase, "_busy"},  32'(busy), 32'd0);
    check({phase, "_done"},  32'(done), 32'd0);
    check({phase, "_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
    check({phase, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({phase, "_data"},  32'(bus.out_data), 32'd0);
    check({phase, "_last"},  32'(bus.out_last), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] gap_state;
    int len;

    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    sys_rst_n = 1'b1;
    flush_all();

    // Full-rate burst of four.
    fill(8'h11); fill(8'h22); fill(8'h33); fill(8'h44);
    start_burst(4);
    wait_done(40);
    repeat (3) @(posedge clk); #1;
    check("full_first_lat", 32'(first_hs - e0), 32'd2);
    check("full_span", 32'(last_hs - first_hs), 32'd3);
    check("full_words", 32'(hs_count), 32'd4);
    check("full_done_lat", 32'(done_cyc - last_hs), 32'd1);
    check("full_rd_cycles", 32'(rd_cnt), 32'd4);
    check("full_done_once", 32'(done_cnt), 32'd1);
    check("full_recv", 32'(dbg_recv), 32'd4);

    // Backpressure with ready 1,0,0 repeating.
    ready_mode = 1;
    for (int i = 0; i < 5; i++) fill(8'($urandom_range(0, 255)));
    start_burst(5);
    wait_done(100);
    check("bp_words", 32'(hs_count), 32'd5);
    check("bp_rd_cycles", 32'(rd_cnt), 32'd5);
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    ready_mode = 0;

    // Empty stall: two words now, two more after a gap.
    fill(8'($urandom_range(0, 255))); fill(8'($urandom_range(0, 255)));
    start_burst(4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    gap_state = dbg_state;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_rd_low", 32'(bus.fifo_rd_en), 32'd0);
      check("stall_state", 32'(dbg_state), 32'(gap_state));
    end
    @(posedge clk); #1;
    fill(8'($urandom_range(0, 255))); fill(8'($urandom_range(0, 255)));
    wait_done(60);
    check("stall_words", 32'(hs_count), 32'd4);
    check("stall_done_once", 32'(done_cnt), 32'd1);

    // Zero length.
    start_burst(0);
    repeat (4) @(posedge clk); #1;
    check("zero_done_once", 32'(done_cnt), 32'd1);
    check("zero_done_lat", 32'(done_cyc - e0), 32'd0);
    check("zero_no_activity", 32'(act_cnt), 32'd0);

    // Start while busy is ignored.
    for (int i = 0; i < 10; i++) fill(8'($urandom_range(0, 255)));
    start_burst(3);
    start = 1'b1;
    burst_len = LEN_W'(7);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60);
    repeat (10) @(posedge clk); #1;
    check("busy_start_words", 32'(hs_count), 32'd3);
    check("busy_start_rd", 32'(rd_cnt), 32'd3);
    check("busy_start_done", 32'(done_cnt), 32'd1);
    flush_all();

    // Reset mid-burst after two of six words.
    for (int i = 0; i < 6; i++) fill(8'($urandom_range(0, 255)));
    start_burst(6);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (hs_count >= 2) break;
    end
    #1;
    check("rst_two_words", 32'(hs_count), 32'd2);
    sys_rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk); #1;
    flush_all();
    sys_rst_n = 1'b1;
    @(posedge clk); #1;
    fill(8'h5A); fill(8'hA5);
    start_burst(2);
    wait_done(40);
    check("post_rst_words", 32'(hs_count), 32'd2);
    check("post_rst_done", 32'(done_cnt), 32'd1);

    // Randomized bursts with random backpressure.
    ready_mode = 2;
    for (int b = 0; b < 6; b++) begin
      len = $urandom_range(1, 15);
      for (int i = 0; i < len; i++) fill(8'($urandom_range(0, 255)));
      start_burst(len);
      wait_done(len * 10 + 40);
      check("rand_words", 32'(hs_count), 32'(len));
      check("rand_rd_cycles", 32'(rd_cnt), 32'(len));
      check("rand_recv", 32'(dbg_recv), 32'(len));
      repeat (2) @(posedge clk); #1;
      check("rand_done_once", 32'(done_cnt), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Downstream drain stage for the on-chip `sync_fifo` in the EKF datapath. On a `start` command, it reads exactly `burst_len` words from the FIFO, absorbing the FIFO's one-cycle registered read latency. It presents the words on a valid/ready stream to the consuming PE, with `last` on the final word. A 2-entry output buffer with credit-based read issue gives full throughput under `out_ready=1` and loses no data under backpressure.

## Interface
- `DATA_LEN`, 8, word width; matches the FIFO data width.
- `LEN_W`, 4, width of the burst length field; max burst is 2^LEN_W-1.

- `clk`  in  1  clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  burst request; sampled only in IDLE.
- `burst_len`  in  LEN_W  words to transfer; sampled with `start`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at burst completion.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  DATA_LEN  FIFO `data_out`; valid the cycle after an issued `fifo_rd_en`.
- `out_valid`  out  1  output word valid.
- `out_data`  out  DATA_LEN  output word.
- `out_last`  out  1  qualifies the final word of the burst.
- `out_ready`  in  1  consumer accepts when high together with `out_valid`.

## Operation
**State machine:** IDLE, RUN, DRAIN.
- IDLE
  - `start` with `burst_len`≠0: latch `len`, clear the `issued`, `recv` and `sent` counters, go to RUN.
  - `start` with `burst_len`=0: pulse `done` the next cycle and stay in IDLE.
- RUN
  - Read issue condition: `fifo_rd_en = !fifo_empty && issued<len && (occ + inflight - pop) < 2`.
  - `occ` is the buffer occupancy (0..2).
  - `inflight` is a register holding the previous cycle's `fifo_rd_en`.
  - `pop = out_valid && out_ready`.
  - `issued` increments on each `fifo_rd_en`.
  - When `issued` reaches `len` on a clock edge, go to DRAIN.
- DRAIN
  - `fifo_rd_en`=0.
  - When the handshake with `out_last`=1 occurs, go to IDLE and pulse `done` the following cycle.

**Datapath rules**
- Capture: when `inflight`=1, write `fifo_data` into the buffer tail at the clock edge and increment `recv`.
- Output:
  - `out_valid = (occ≠0)`.
  - `out_data` is the buffer head.
  - `out_last = out_valid && (sent == len-1)`.
  - `sent` increments on each pop.
- Simultaneous push and pop: `occ` is unchanged, head and tail both advance, and the buffer pointers wrap modulo 2.
- The credit rule guarantees no push into a full buffer. An overflow is a design error; the bench asserts `occ≤2` always.
- `fifo_rd_en` is never asserted while `fifo_empty`=1, so every issued read returns data.
- `start` during RUN or DRAIN is ignored; the latched `len` is unaffected.
- Counters are LEN_W bits wide and never wrap within a burst.

**Reset** (asynchronous, any state, including mid-burst):
- State goes to IDLE.
- `occ`, the pointers, all counters and `inflight` clear to 0.
- All outputs go to 0: `busy`, `done`, `fifo_rd_en`, `out_valid`, `out_data`, `out_last`.
- Buffered or in-flight words are discarded; the FIFO is not rewound.

## Timing
- `start` sampled at edge E0.
- `busy`=1 and `fifo_rd_en` may be high in the cycle after E0.
- First word: the FIFO registers it at E1 and the buffer captures it at E2. `out_valid` rises after E2, two cycles after the start edge when the FIFO is non-empty.
- Steady state with `out_ready`=1 and a non-empty FIFO: one word per cycle.
- Stall behaviour:
  - `fifo_empty` pauses issue and resumes on the first non-empty cycle.
  - `out_ready`=0 fills the buffer to 2, after which issue stops.
- `done` is high exactly one cycle, the cycle after the last handshake. `busy` falls at the same edge that raises `done`.

## Test plan
- **Full-rate burst:** FIFO prefilled with 0x11,0x22,0x33,0x44; `start`, `burst_len`=4; `out_ready`=1.
  - Words appear on 4 consecutive cycles starting 2 cycles after the start edge.
  - `out_last` is high only with 0x44.
  - `done` pulses the next cycle and `fifo_rd_en` was high exactly 4 cycles.
- **Backpressure:** `burst_len`=5 with `out_ready` toggling 1,0,0,1,…
  - All 5 words are delivered in order with none duplicated or lost.
  - `occ` never exceeds 2.
  - `fifo_rd_en` stays low while the buffer is full.
- **Empty stall:** FIFO holds 2 words, `burst_len`=4, 2 more words written 6 cycles later.
  - The block stays in RUN with `fifo_rd_en`=0 during the gap.
  - It completes after the late writes; `out_last` is on the 4th word.
- **Zero length:** `start` with `burst_len`=0.
  - `done` pulses one cycle later.
  - `busy`, `fifo_rd_en` and `out_valid` stay 0.
- **Start while busy:** a second `start` with `burst_len`=7 mid-burst of length 3 is ignored.
  - Exactly 3 words are delivered and one `done` pulse occurs.
- **Reset mid-burst:** assert `sys_rst_n`=0 after 2 of 6 words.
  - All outputs go to 0 immediately.
  - After release, a new burst of 2 completes normally.
